// File: rtl/population_count_sequencer.sv
// Multi-cycle popcount: one CHUNK_WIDTH slice of the operand per clock, valid/ready on both sides.
// Optional POPCOUNT_EARLY_EXIT_EN finishes as soon as the remaining operand bits are all zero.
module population_count_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8,
    parameter int CHUNKS      = DATA_WIDTH / CHUNK_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         operand_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [$clog2(DATA_WIDTH):0]   count_o,
    output logic                          valid_o,
    input  logic                          ready_i
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam int PC_W  = $clog2(CHUNK_WIDTH) + 1;
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PC_W-1:0]         chunk_cnt;

    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++)
            chunk_cnt = chunk_cnt + PC_W'(shift_q[i]);
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (valid_i && ready_o) begin
                    shift_d = operand_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                acc_d   = acc_q + CNT_W'(chunk_cnt);
                shift_d = shift_q >> CHUNK_WIDTH;
                idx_d   = idx_q + IDX_W'(1);
`ifdef POPCOUNT_EARLY_EXIT_EN
                // shift_d is what is left to count; nothing set means the sum is final
                if (idx_q == LAST_IDX || shift_d == '0) state_d = DONE;
`else
                if (idx_q == LAST_IDX) state_d = DONE;
`endif
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // ready is gated by reset so nothing handshakes while the block is held
    assign ready_o = (state_q == IDLE) && !rst_i;
    assign valid_o = (state_q == DONE);
    assign count_o = acc_q;

endmodule

// File: tb/tb_population_count_sequencer.sv
// Bench for population_count_sequencer: directed and random operands against a popcount/latency model.
module tb_population_count_sequencer;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NCH = DW / CW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] operand_i;
    logic          valid_i;
    logic          ready_o;
    logic [5:0]    count_o;
    logic          valid_o;
    logic          ready_i;

    int total = 0;
    int bad = 0;

    population_count_sequencer #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .operand_i(operand_i), .valid_i(valid_i),
        .ready_o(ready_o), .count_o(count_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int exp_cnt(input logic [DW-1:0] op);
        return $countones(op);
    endfunction

    // count cycles: all chunks, or with early exit up to the highest non-zero chunk (min 1)
    function automatic int exp_lat(input logic [DW-1:0] op);
`ifdef POPCOUNT_EARLY_EXIT_EN
        for (int b = DW - 1; b >= 0; b--)
            if (op[b]) return b / CW + 1;
        return 1;
`else
        return NCH;
`endif
    endfunction

    // Presents op while IDLE; returns edges from acceptance to valid_o, or -1 on timeout.
    task automatic do_op(input logic [DW-1:0] op, output int lat, output logic [5:0] cnt);
        valid_i = 1'b1;
        operand_i = op;
        tick();
        valid_i = 1'b0;
        operand_i = $urandom;
        lat = -1;
        cnt = 'x;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (valid_o) begin
                lat = k;
                cnt = count_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; operand_i = '1;
        tick(); tick();
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (count_o !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
        rst_i = 1'b0; valid_i = 1'b0;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", ready_o); end
        tick();
        total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL post_reset_idle valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
        end
    endtask

    task automatic test_all_ones();
        int lat; logic [5:0] cnt;
        ready_i = 1'b1;
        do_op('1, lat, cnt);
        total++; if (lat != exp_lat('1)) begin bad++; $display("FAIL ones_latency got=%0d want=%0d", lat, exp_lat('1)); end
        total++; if (cnt !== 6'd32) begin bad++; $display("FAIL ones_count got=%0d want=32", cnt); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL ones_ready_in_done got=%b want=0", ready_o); end
        tick();
        total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL ones_release valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
        end
    endtask

    task automatic test_directed();
        logic [DW-1:0] ops [4] = '{32'h0000_0000, 32'h8000_0001, 32'h0000_00FF, 32'h00FF_0000};
        int lat; logic [5:0] cnt;
        ready_i = 1'b1;
        foreach (ops[i]) begin
            do_op(ops[i], lat, cnt);
            total++; if (cnt !== 6'(exp_cnt(ops[i]))) begin
                bad++; $display("FAIL directed_count op=%h got=%0d want=%0d", ops[i], cnt, exp_cnt(ops[i]));
            end
            total++; if (lat != exp_lat(ops[i])) begin
                bad++; $display("FAIL directed_latency op=%h got=%0d want=%0d", ops[i], lat, exp_lat(ops[i]));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [5:0] cnt;
        ready_i = 1'b0;
        do_op(32'h0F0F_0F0F, lat, cnt);
        total++; if (cnt !== 6'd16) begin bad++; $display("FAIL bp_count got=%0d want=16", cnt); end
        valid_i = 1'b1; operand_i = 32'h0000_0007;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (valid_o !== 1'b1 || count_o !== 6'd16 || ready_o !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d valid=%b count=%0d ready=%b want 1/16/0", i, valid_o, count_o, ready_o);
            end
        end
        ready_i = 1'b1;
        tick();
        total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL bp_release valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
        end
        do_op(32'h0000_0007, lat, cnt);
        total++; if (cnt !== 6'd3 || lat != exp_lat(32'h7)) begin
            bad++; $display("FAIL bp_next count=%0d lat=%0d want count=3 lat=%0d", cnt, lat, exp_lat(32'h7));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat; logic [5:0] cnt; bit rose = 0;
        ready_i = 1'b1;
        valid_i = 1'b1; operand_i = '1;
        tick();
        valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        total++; if (valid_o !== 1'b0 || ready_o !== 1'b0 || count_o !== 6'd0) begin
            bad++; $display("FAIL midrst_during valid=%b ready=%b count=%0d want 0/0/0", valid_o, ready_o, count_o);
        end
        rst_i = 1'b0;
        tick();
        total++; if (ready_o !== 1'b1 || count_o !== 6'd0) begin
            bad++; $display("FAIL midrst_after ready=%b count=%0d want ready=1 count=0", ready_o, count_o);
        end
        for (int i = 0; i < 6; i++) begin
            if (valid_o) rose = 1;
            tick();
        end
        total++; if (rose) begin bad++; $display("FAIL midrst_valid_rose got=1 want=0"); end
        do_op(32'h0000_0003, lat, cnt);
        total++; if (cnt !== 6'd2 || lat != exp_lat(32'h3)) begin
            bad++; $display("FAIL midrst_next count=%0d lat=%0d want count=2 lat=%0d", cnt, lat, exp_lat(32'h3));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] ops [3] = '{32'h0000_0001, 32'hFFFF_0000, 32'h1234_5678};
        logic [5:0] res_cnt [3];
        int res_t [3];
        int n_acc = 0, n_res = 0, cyc = 0;
        bit acc;
        ready_i = 1'b1; valid_i = 1'b1; operand_i = ops[0];
        for (int c = 0; c < 100 && n_res < 3; c++) begin
            acc = ready_o && valid_i;
            tick();
            cyc++;
            if (acc) begin
                n_acc++;
                if (n_acc < 3) operand_i = ops[n_acc];
                else valid_i = 1'b0;
            end
            if (valid_o) begin
                res_cnt[n_res] = count_o;
                res_t[n_res] = cyc;
                n_res++;
            end
        end
        valid_i = 1'b0;
        total++; if (n_res != 3) begin bad++; $display("FAIL b2b_results got=%0d want=3", n_res); end
        else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (res_cnt[i] !== 6'(exp_cnt(ops[i]))) begin
                    bad++; $display("FAIL b2b_count idx=%0d got=%0d want=%0d", i, res_cnt[i], exp_cnt(ops[i]));
                end
            end
            total++; if (res_t[0] != 1 + exp_lat(ops[0])) begin
                bad++; $display("FAIL b2b_first_time got=%0d want=%0d", res_t[0], 1 + exp_lat(ops[0]));
            end
            for (int i = 1; i < 3; i++) begin
                total++; if (res_t[i] - res_t[i-1] != exp_lat(ops[i]) + 2) begin
                    bad++; $display("FAIL b2b_interval idx=%0d got=%0d want=%0d", i, res_t[i] - res_t[i-1], exp_lat(ops[i]) + 2);
                end
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] op;
        int lat, hold; logic [5:0] cnt;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: op = $urandom;
                1: op = $urandom & 32'h0000_FFFF;
                2: op = $urandom & 32'h0000_00FF;
                default: op = $urandom & 32'h00FF_F000;
            endcase
            hold = $urandom_range(0, 3);
            ready_i = (hold == 0);
            do_op(op, lat, cnt);
            total++; if (cnt !== 6'(exp_cnt(op)) || lat != exp_lat(op)) begin
                bad++; $display("FAIL rand_result op=%h count=%0d lat=%0d want count=%0d lat=%0d", op, cnt, lat, exp_cnt(op), exp_lat(op));
            end
            valid_i = 1'b1; operand_i = $urandom;
            for (int h = 0; h < hold; h++) begin
                tick();
                total++; if (valid_o !== 1'b1 || count_o !== 6'(exp_cnt(op)) || ready_o !== 1'b0) begin
                    bad++; $display("FAIL rand_hold op=%h valid=%b count=%0d ready=%b", op, valid_o, count_o, ready_o);
                end
            end
            ready_i = 1'b1;
            tick();
            valid_i = 1'b0;
            total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                bad++; $display("FAIL rand_release valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; operand_i = '0;
        test_reset();
        test_all_ones();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/population_count_sequencer.md
# population_count_sequencer

Multi-cycle population count unit that sequences a narrow CHUNK_WIDTH-bit ones-counting datapath over a DATA_WIDTH-bit operand, one chunk per clock. It trades the latency of the fully combinational counter for a single small chunk counter and an accumulator. It sits behind a valid/ready handshake on both input and output, so it can be placed directly in a pipelined execution unit with backpressure.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width; must be a power of 2 and at least CHUNK_WIDTH.
- CHUNK_WIDTH, 8, bits counted per cycle; must be a power of 2 that divides DATA_WIDTH.
- CHUNKS, DATA_WIDTH / CHUNK_WIDTH, derived; number of count cycles. Do not override.

Ports:
- clk_i  in  1  clock. Single clock domain.
- rst_i  in  1  reset. Synchronous, active-high.
- operand_i  in  DATA_WIDTH  word to count. Sampled only on an input handshake.
- valid_i  in  1  operand_i is valid.
- ready_o  out  1  block can accept an operand.
- count_o  out  $clog2(DATA_WIDTH)+1  number of ones in the accepted operand.
- valid_o  out  1  count_o holds a valid result.
- ready_i  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, COUNT, DONE. Reset state is IDLE.
- IDLE:
  - ready_o=1, valid_o=0.
  - On valid_i && ready_o: load operand_i into a shift register, clear the accumulator and chunk index, and go to COUNT.
- COUNT:
  - ready_o=0, valid_o=0.
  - Each cycle: accumulator += popcount(shift_reg[CHUNK_WIDTH-1:0]); shift right by CHUNK_WIDTH; increment the index.
  - When the index equals CHUNKS-1, go to DONE.
- DONE:
  - valid_o=1, ready_o=0, and count_o holds the accumulator value.
  - On ready_i=1: go to IDLE.
  - While ready_i=0: count_o and valid_o stay stable. valid_i is ignored.
- Arithmetic:
  - The chunk popcount is $clog2(CHUNK_WIDTH)+1 bits wide.
  - The accumulator is $clog2(DATA_WIDTH)+1 bits wide, so it cannot overflow: the maximum is DATA_WIDTH, e.g. 32 is representable in 6 bits.
  - The chunk popcount is zero-extended before the add.
- Output ownership: count_o is driven directly by the accumulator register. Its value is meaningful only while valid_o=1.
- Operand capture: an operand is captured only in IDLE. operand_i changing during COUNT or DONE has no effect.
- No input queuing: a new operand is accepted no earlier than the cycle after the DONE handshake.

## Timing
- Reset:
  - While rst_i=1 at a clock edge: state becomes IDLE, accumulator 0, index 0, shift register 0.
  - Outputs during reset: count_o=0, valid_o=0, ready_o=0. ready_o is gated by rst_i.
  - Handshakes presented during reset are ignored.
- Latency: the input handshake occurs at edge E0. valid_o rises after edge E(CHUNKS); with defaults this is 4 cycles after acceptance.
- Throughput: one result per CHUNKS+2 cycles when ready_i is held high (6 cycles with defaults).
- Output release: the DONE handshake at edge Ek drops valid_o and raises ready_o in the cycle after Ek.
- Reset mid-operation: a reset in COUNT or DONE aborts the operation. The result is never presented, and the block is in IDLE with all outputs at reset values on the cycle after rst_i deasserts.
- Simultaneous events: valid_i=1 while in DONE is not accepted, even if ready_i=1 in that same cycle.
- Degenerate size: CHUNKS=1 (DATA_WIDTH==CHUNK_WIDTH) yields exactly one COUNT cycle.

## Configuration
- Macro: POPCOUNT_EARLY_EXIT_EN.
- Defined:
  - In COUNT, the FSM goes to DONE after the current chunk if the shifted remainder is all zero, or if the index equals CHUNKS-1.
  - Latency becomes 1..CHUNKS cycles, depending on the position of the highest set chunk.
  - A zero operand completes in 1 count cycle.
- Not defined: latency is always exactly CHUNKS count cycles, independent of the data, and the zero-detect logic is not synthesized.
- The count result is identical in both builds.

## Test plan
- All ones, macro off: operand_i=32'hFFFFFFFF with ready_i=1 -> valid_o high 4 cycles after acceptance, count_o=32, ready_o high on the following cycle.
- Zero operand:
  - macro off: operand_i=32'h00000000 -> count_o=0 after 4 cycles.
  - macro on: operand_i=32'h00000000 -> count_o=0 after 1 cycle.
- Sparse bits:
  - operand_i=32'h80000001 -> count_o=2 after 4 cycles in both builds.
  - macro on: operand_i=32'h000000FF -> count_o=8 after 1 cycle.
- Backpressure: operand 32'h0F0F0F0F with ready_i=0 for 3 cycles after valid_o rises, while valid_i=1 with a new operand -> count_o=16 stays stable, ready_o=0, new operand not accepted; ready_i=1 -> handshake, then the new operand is accepted in IDLE.
- Reset mid-COUNT: accept 32'hFFFFFFFF, assert rst_i in the 2nd COUNT cycle for 1 cycle -> valid_o never rises, count_o=0, ready_o=1 the cycle after reset; the next operand 32'h00000003 yields 2.
- Back-to-back: stream 32'h00000001, 32'hFFFF0000, 32'h12345678 with ready_i=1 -> results 1, 16, 13 in order, one every 6 cycles with the macro off.
